// File: rtl/weight_buf_pkg.sv
// Shared types and geometry for the 16-bank weight buffer.
// Used by both the read-side fetch controller and the write-side loader.
package weight_buf_pkg;

  localparam int SRAM_DEPTH = 50;
  localparam int BAND_WIDTH = 16;
  localparam int DATA_WIDTH = 8;
  localparam int AW         = $clog2(SRAM_DEPTH);
  localparam int CW         = AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wfetch_state_t;

  function automatic logic [AW-1:0] wrap_addr(
    input logic [AW-1:0] base,
    input logic [AW:0]   k
  );
    logic [AW:0] s;
    logic [AW:0] d;
    d = (AW+1)'(SRAM_DEPTH);
    s = {1'b0, base} + k;
    if (s >= d) s = s - d;
    return s[AW-1:0];
  endfunction

endpackage

// File: rtl/wfetch_lane.sv
// One lane of the weight fetch: skewed read issue, valid pipe and
// capture register for that bank's read data.
module wfetch_lane
  import weight_buf_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [CW-1:0]         cnt,
  input  logic [AW-1:0]         base,
  input  logic [AW:0]           len,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  enb,
  output logic [AW-1:0]         addrb,
  output logic                  w_valid,
  output logic [DATA_WIDTH-1:0] w_data
);

  logic [CW-1:0] k;
  logic          hit;
  logic          v1;

  assign k   = cnt - CW'(LANE);
  assign hit = run
             && (cnt >= CW'(LANE))
             && (k < CW'(len));

  always_ff @(posedge clk) begin
    if (rst) begin
      enb     <= 1'b0;
      addrb   <= '0;
      v1      <= 1'b0;
      w_valid <= 1'b0;
      w_data  <= '0;
    end else begin
      enb     <= hit;
      if (hit) addrb <= wrap_addr(base, k[AW:0]);
      v1      <= enb;
      w_valid <= v1;
      if (v1) w_data <= dob;
    end
  end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Read-side sequencer for the 16-bank weight buffer: streams len words per
// bank with a one-cycle-per-lane diagonal skew for the systolic array.
module weight_fetch_ctrl
  import weight_buf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BAND_WIDTH-1:0] enb,
  output logic [AW-1:0]         addrb  [BAND_WIDTH-1:0],
  input  logic [DATA_WIDTH-1:0] dob    [BAND_WIDTH-1:0],
  output logic [DATA_WIDTH-1:0] w_data [BAND_WIDTH-1:0],
  output logic [BAND_WIDTH-1:0] w_valid
);

  wfetch_state_t state;

  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] iss_cnt;
  logic [AW-1:0] base_q;
  logic [AW-1:0] iss_base;
  logic [AW:0]   len_q;
  logic [AW:0]   len_c;
  logic [AW:0]   iss_len;
  logic          drain_q;
  logic          bad;
  logic          idle;
  logic          iss_run;

  assign idle  = (state == IDLE);
  assign bad   = base_addr >= AW'(SRAM_DEPTH);
  assign len_c = (len > (AW+1)'(SRAM_DEPTH))
               ? (AW+1)'(SRAM_DEPTH) : len;
  assign last  = CW'(len_q) + CW'(BAND_WIDTH - 2);

  // Lanes register the step the counter is about to take, so enb
  // lines up with cnt in the same cycle.
  assign iss_run  = idle ? (start && !bad)
                         : ((state == RUN) && (cnt != last));
  assign iss_cnt  = idle ? '0 : cnt + CW'(1);
  assign iss_base = idle ? base_addr : base_q;
  assign iss_len  = idle ? len_c : len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      base_q  <= '0;
      len_q   <= '0;
      drain_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (bad) begin
              err <= 1'b1;
            end else begin
              base_q <= base_addr;
              len_q  <= len_c;
              cnt    <= '0;
              busy   <= 1'b1;
              if (len_c == '0) begin
                state   <= DRAIN;
                drain_q <= 1'b1;
                done    <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == last) begin
            state   <= DRAIN;
            drain_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_q) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            drain_q <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < BAND_WIDTH; i++) begin : g_lane
    wfetch_lane #(
      .LANE(i)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .run     (iss_run),
      .cnt     (iss_cnt),
      .base    (iss_base),
      .len     (iss_len),
      .dob     (dob[i]),
      .enb     (enb[i]),
      .addrb   (addrb[i]),
      .w_valid (w_valid[i]),
      .w_data  (w_data[i])
    );
  end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: bank memory model plus a per-cycle
// expectation built from base/len arithmetic for every lane.
module tb_weight_fetch_ctrl;
  import weight_buf_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [AW:0]           len;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BAND_WIDTH-1:0] enb;
  logic [AW-1:0]         addrb  [BAND_WIDTH-1:0];
  logic [DATA_WIDTH-1:0] dob    [BAND_WIDTH-1:0];
  logic [DATA_WIDTH-1:0] w_data [BAND_WIDTH-1:0];
  logic [BAND_WIDTH-1:0] w_valid;

  logic [DATA_WIDTH-1:0] mem [BAND_WIDTH][SRAM_DEPTH];

  int total = 0;
  int bad   = 0;

  weight_fetch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .enb       (enb),
    .addrb     (addrb),
    .dob       (dob),
    .w_data    (w_data),
    .w_valid   (w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < BAND_WIDTH; i++)
      if (enb[i]) dob[i] <= mem[i][addrb[i]];
  end

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < BAND_WIDTH; i++)
      for (int a = 0; a < SRAM_DEPTH; a++)
        mem[i][a] = rnd ? DATA_WIDTH'($urandom)
                        : DATA_WIDTH'(a + i);
  endtask

  task automatic run_cmd(input int b, input int l,
                         input bit poke, input string tag);
    int leff;
    int dcyc;
    int k;
    int bl;
    logic [BAND_WIDTH-1:0] e_en;
    logic [BAND_WIDTH-1:0] e_wv;
    logic [AW-1:0] ea;
    logic [AW-1:0] ga;
    logic [DATA_WIDTH-1:0] ed;
    logic [DATA_WIDTH-1:0] gd;
    bit a_bad;
    bit d_bad;
    leff = (l > SRAM_DEPTH) ? SRAM_DEPTH : l;
    dcyc = (leff == 0) ? 1 : leff + BAND_WIDTH + 1;
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    @(posedge clk);
    for (int j = 1; j <= dcyc + 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      e_en = '0;
      e_wv = '0;
      a_bad = 0;
      d_bad = 0;
      bl = 0;
      ea = '0; ga = '0; ed = '0; gd = '0;
      for (int i = 0; i < BAND_WIDTH; i++) begin
        k = j - 1 - i;
        if (k >= 0 && k < leff) begin
          e_en[i] = 1'b1;
          if (!a_bad && addrb[i] !== AW'((b + k) % SRAM_DEPTH)) begin
            a_bad = 1;
            bl = i;
            ea = AW'((b + k) % SRAM_DEPTH);
            ga = addrb[i];
          end
        end
        k = j - 3 - i;
        if (k >= 0 && k < leff) begin
          e_wv[i] = 1'b1;
          if (!d_bad &&
              w_data[i] !== mem[i][(b + k) % SRAM_DEPTH]) begin
            d_bad = 1;
            bl = i;
            ed = mem[i][(b + k) % SRAM_DEPTH];
            gd = w_data[i];
          end
        end
      end
      total++;
      if (enb !== e_en) begin
        bad++;
        $display("FAIL %s enb cyc=%0d got=%h exp=%h", tag, j, enb, e_en);
      end
      if (e_en != '0) begin
        total++;
        if (a_bad) begin
          bad++;
          $display("FAIL %s addrb cyc=%0d lane=%0d got=%0d exp=%0d",
                   tag, j, bl, ga, ea);
        end
      end
      total++;
      if (w_valid !== e_wv) begin
        bad++;
        $display("FAIL %s w_valid cyc=%0d got=%h exp=%h",
                 tag, j, w_valid, e_wv);
      end
      if (e_wv != '0) begin
        total++;
        if (d_bad) begin
          bad++;
          $display("FAIL %s w_data cyc=%0d lane=%0d got=%0d exp=%0d",
                   tag, j, bl, gd, ed);
        end
      end
      total++;
      if (busy !== (j <= dcyc)) begin
        bad++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b",
                 tag, j, busy, (j <= dcyc));
      end
      total++;
      if (done !== (j == dcyc) || err !== 1'b0) begin
        bad++;
        $display("FAIL %s done/err cyc=%0d got=%b/%b exp=%b/0",
                 tag, j, done, err, (j == dcyc));
      end
      if (poke && (j == 5 || j == dcyc)) begin
        start     = 1'b1;
        base_addr = AW'($urandom_range(0, SRAM_DEPTH - 1));
        len       = (AW+1)'($urandom_range(1, 60));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [AW-1:0] ao;
    logic [DATA_WIDTH-1:0] dd;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ao = '0;
    dd = '0;
    for (int i = 0; i < BAND_WIDTH; i++) begin
      ao |= addrb[i];
      dd |= w_data[i];
    end
    total++;
    if ({busy, done, err} !== 3'b000 || enb !== '0 || w_valid !== '0) begin
      bad++;
      $display("FAIL reset ctl got busy=%b done=%b err=%b enb=%h wv=%h exp=0",
               busy, done, err, enb, w_valid);
    end
    total++;
    if (ao !== '0 || dd !== '0) begin
      bad++;
      $display("FAIL reset data got addr_or=%h data_or=%h exp=0", ao, dd);
    end
    rst = 1'b0;
  endtask

  task automatic test_err;
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'($urandom_range(SRAM_DEPTH, (1 << AW) - 1));
    len       = (AW+1)'($urandom_range(1, 20));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || enb !== '0) begin
      bad++;
      $display("FAIL err_pulse got err=%b busy=%b done=%b enb=%h exp=1/0/0/0",
               err, busy, done, enb);
    end
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      total++;
      if ({err, busy, done} !== 3'b000 || enb !== '0 || w_valid !== '0) begin
        bad++;
        $display("FAIL err_after cyc=%0d got err=%b busy=%b done=%b enb=%h exp=0",
                 j, err, busy, done, enb);
      end
    end
    run_cmd(7, 3, 0, "after_err");
  endtask

  task automatic test_reset_mid;
    fill_mem(1);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'($urandom_range(0, SRAM_DEPTH - 1));
    len       = (AW+1)'(20);
    @(posedge clk);
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done} !== 2'b00 || enb !== '0 || w_valid !== '0) begin
      bad++;
      $display("FAIL rst_mid got busy=%b done=%b enb=%h wv=%h exp=0",
               busy, done, enb, w_valid);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00 || enb !== '0 || w_valid !== '0) begin
        bad++;
        $display("FAIL rst_mid_after cyc=%0d got busy=%b enb=%h wv=%h exp=0",
                 j, busy, enb, w_valid);
      end
    end
    run_cmd($urandom_range(0, SRAM_DEPTH - 1), 20, 0, "rst_fresh");
  endtask

  task automatic test_random;
    for (int n = 0; n < 6; n++) begin
      fill_mem(1);
      run_cmd($urandom_range(0, SRAM_DEPTH - 1), $urandom_range(0, 70),
              1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    test_reset;
    fill_mem(1);
    run_cmd(0, 4, 0, "basic");
    fill_mem(0);
    run_cmd(45, 10, 0, "wrap");
    run_cmd(12, 0, 0, "len0");
    test_err;
    fill_mem(1);
    run_cmd(0, 4, 1, "restart");
    run_cmd(3, 90, 0, "clamp");
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
